// File: rtl/data_mem_wait.sv
// Byte-masked synchronous data memory behind a valid/ready request/response
// handshake, with a programmable number of wait states per access.
module data_mem_wait #(
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 1024,
    parameter int ADDR_W      = 32,
    parameter int WAIT_CYCLES = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [DATA_W/8-1:0]   req_mask,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  rsp_err
);

    localparam int NB     = DATA_W / 8;
    localparam int LSB    = $clog2(NB);
    localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_e;

    state_e              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                we_q, we_d;
    logic [NB-1:0]       mask_q, mask_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic                rsp_err_q, rsp_err_d;
    logic                rsp_ok_q, rsp_ok_d;
    logic [DATA_W-1:0]   mem_rdata_q;
    logic                access;

    logic [DATA_W-1:0]   mem [DEPTH];

    logic [ADDR_W-1:0]   idx;
    logic [MEM_AW-1:0]   mem_idx;
    logic                misaligned;
    logic                in_range;
    logic                bad;

    assign idx        = addr_q >> LSB;
    assign mem_idx    = idx[MEM_AW-1:0];
    assign misaligned = (addr_q & ADDR_W'(NB - 1)) != '0;
    assign in_range   = idx < ADDR_W'(DEPTH);
    assign bad        = misaligned || !in_range;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        mask_d      = mask_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rsp_valid_d = rsp_valid_q;
        rsp_err_d   = rsp_err_q;
        rsp_ok_d    = rsp_ok_q;
        access      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    mask_d  = req_mask;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    cnt_d   = 4'(WAIT_CYCLES);
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    access      = 1'b1;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = bad;
                    // only a good load exposes memory data
                    rsp_ok_d    = !we_q && !bad;
                    state_d     = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            we_q        <= 1'b0;
            mask_q      <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_ok_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            mask_q      <= mask_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_ok_q    <= rsp_ok_d;
        end
    end

    // Storage has no reset; a reset edge suppresses any access.
    always_ff @(posedge clk) begin
        if (rst && access && !bad) begin
            if (we_q) begin
                for (int i = 0; i < NB; i++) begin
                    if (mask_q[i]) begin
                        mem[mem_idx][8*i +: 8] <= wdata_q[8*i +: 8];
                    end
                end
            end else begin
                mem_rdata_q <= mem[mem_idx];
            end
        end
    end

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_ok_q ? mem_rdata_q : '0;

endmodule

// File: tb/tb_data_mem_wait.sv
// Directed scoreboard bench for data_mem_wait: one instance with 2 wait
// states and one with 4, sharing a stimulus bus selected by sel.
module tb_data_mem_wait;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sel = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [3:0]  req_mask = '0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_ready = 1'b0;

    logic        req_ready, rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;

    logic        a_req_ready, a_rsp_valid, a_rsp_err;
    logic [31:0] a_rsp_rdata;
    logic        b_req_ready, b_rsp_valid, b_rsp_err;
    logic [31:0] b_rsp_rdata;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    data_mem_wait #(.WAIT_CYCLES(2)) u_a (
        .clk(clk), .rst(rst),
        .req_valid(req_valid & ~sel), .req_ready(a_req_ready),
        .req_we(req_we), .req_mask(req_mask),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(a_rsp_valid), .rsp_ready(rsp_ready & ~sel),
        .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err)
    );

    data_mem_wait #(.WAIT_CYCLES(4)) u_b (
        .clk(clk), .rst(rst),
        .req_valid(req_valid & sel), .req_ready(b_req_ready),
        .req_we(req_we), .req_mask(req_mask),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(b_rsp_valid), .rsp_ready(rsp_ready & sel),
        .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err)
    );

    assign req_ready = sel ? b_req_ready : a_req_ready;
    assign rsp_valid = sel ? b_rsp_valid : a_rsp_valid;
    assign rsp_err   = sel ? b_rsp_err   : a_rsp_err;
    assign rsp_rdata = sel ? b_rsp_rdata : a_rsp_rdata;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_req(input logic we, input logic [3:0] mask,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_rd, input logic exp_err,
                          input int hold);
        int   edges;
        int   lat;
        exp_t e;
        lat = sel ? 5 : 3;
        @(negedge clk);
        chk("req_ready_idle", 64'(req_ready), 64'd1);
        req_valid = 1'b1;
        req_we    = we;
        req_mask  = mask;
        req_addr  = addr;
        req_wdata = wdata;
        sb.push_back('{rdata: exp_rd, err: exp_err});
        @(negedge clk);
        req_valid = 1'b0;
        req_we    = 1'($urandom);
        req_mask  = 4'($urandom);
        req_addr  = $urandom;
        req_wdata = $urandom;
        edges = 0;
        while (!rsp_valid && edges < 32) begin
            @(negedge clk);
            edges++;
        end
        chk("latency", 64'(edges), 64'(lat));
        e = sb.pop_front();
        chk("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
        chk("rsp_err", 64'(rsp_err), 64'(e.err));
        chk("req_ready_resp", 64'(req_ready), 64'd0);
        repeat (hold) begin
            @(negedge clk);
            chk("hold_valid", 64'(rsp_valid), 64'd1);
            chk("hold_rdata", 64'(rsp_rdata), 64'(e.rdata));
            chk("hold_err", 64'(rsp_err), 64'(e.err));
            chk("hold_ready", 64'(req_ready), 64'd0);
        end
        // a request offered on the consume edge must not be taken
        rsp_ready = 1'b1;
        req_valid = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        req_valid = 1'b0;
        chk("consume_valid", 64'(rsp_valid), 64'd0);
        chk("consume_idle", 64'(req_ready), 64'd1);
    endtask

    initial begin
        int seen;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        chk("rst_req_ready", 64'(req_ready), 64'd1);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
        chk("rst_rsp_err", 64'(rsp_err), 64'd0);

        do_req(1'b1, 4'hF, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 0);
        do_req(1'b0, 4'h0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 0);

        do_req(1'b1, 4'hF, 32'h20, 32'h11223344, 32'h0, 1'b0, 0);
        do_req(1'b1, 4'h5, 32'h20, 32'hAABBCCDD, 32'h0, 1'b0, 0);
        do_req(1'b0, 4'hF, 32'h20, 32'h0, 32'h11BB33DD, 1'b0, 0);

        do_req(1'b0, 4'hF, 32'h22, 32'h0, 32'h0, 1'b1, 0);
        do_req(1'b0, 4'hF, 32'h1000, 32'h0, 32'h0, 1'b1, 0);
        do_req(1'b1, 4'hF, 32'h0, 32'h55AA55AA, 32'h0, 1'b0, 0);
        do_req(1'b1, 4'hF, 32'h1000, 32'hFFFFFFFF, 32'h0, 1'b1, 0);
        do_req(1'b1, 4'hF, 32'h23, 32'hFFFFFFFF, 32'h0, 1'b1, 0);
        do_req(1'b0, 4'h0, 32'h0, 32'h0, 32'h55AA55AA, 1'b0, 0);
        do_req(1'b0, 4'h0, 32'h20, 32'h0, 32'h11BB33DD, 1'b0, 0);

        do_req(1'b1, 4'h0, 32'h10, 32'h12345678, 32'h0, 1'b0, 0);
        do_req(1'b0, 4'hF, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 0);

        do_req(1'b0, 4'hF, 32'h20, 32'h0, 32'h11BB33DD, 1'b0, 5);

        // second instance: reset while still counting wait states
        sel = 1'b1;
        do_req(1'b1, 4'hF, 32'h40, 32'h01020304, 32'h0, 1'b0, 0);
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_mask  = 4'hF;
        req_addr  = 32'h40;
        req_wdata = 32'hCAFEF00D;
        @(negedge clk);
        req_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        chk("midrst_idle", 64'(req_ready), 64'd1);
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        chk("midrst_no_rsp", 64'(seen), 64'd0);
        do_req(1'b0, 4'hF, 32'h40, 32'h0, 32'h01020304, 1'b0, 0);

        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/data_mem_wait.md
# data_mem_wait

Parametrised, byte-masked data memory for the core's memory stage, fronted by a valid/ready request/response handshake and a programmable wait-state counter. It replaces the single-cycle asynchronous-read data memory: reads become synchronous (BRAM-friendly), latency is configurable to model slow memory, and bad addresses are flagged. The load/store unit drives requests and holds the pipeline while `req_ready` or `rsp_valid` is low.

## Interface
- `DATA_W`, 32: data word width in bits; must be a multiple of 8; `NB = DATA_W/8` byte lanes.
- `DEPTH`, 1024: number of words; need not be a power of two.
- `ADDR_W`, 32: byte-address width.
- `WAIT_CYCLES`, 0: extra wait states per access, 0..15.
- `clk` input 1: single clock; all state changes on rising edge.
- `rst` input 1: synchronous, active-low reset.
- `req_valid` input 1: request present.
- `req_ready` output 1: block can accept a request.
- `req_we` input 1: 1 = store, 0 = load.
- `req_mask` input NB: byte enables for stores; ignored for loads.
- `req_addr` input ADDR_W: byte address.
- `req_wdata` input DATA_W: store data, lane i = bits [8i+7:8i].
- `rsp_valid` output 1: response present.
- `rsp_ready` input 1: consumer takes the response.
- `rsp_rdata` output DATA_W: load data; 0 for stores and errors.
- `rsp_err` output 1: access was misaligned or out of range.

## Operation
- States: IDLE, BUSY, RESP. `req_ready = (state == IDLE)`.
- IDLE: on `req_valid`, request is accepted. Latch we/mask/addr/wdata, set `cnt <= WAIT_CYCLES`, go to BUSY.
- BUSY: if `cnt != 0`, decrement `cnt`. If `cnt == 0`, perform the access at this edge, register the response, set `rsp_valid <= 1`, and go to RESP.
- RESP: `rsp_valid`, `rsp_rdata` and `rsp_err` hold stable until `rsp_ready`. On an edge with `rsp_ready`, clear `rsp_valid` and go to IDLE. A new request is not accepted in that same cycle.
- Word index: `idx = addr >> log2(NB)`.
- Misaligned: `addr[log2(NB)-1:0] != 0`.
- Out of range: `idx >= DEPTH`.
- Error access: no memory write; `rsp_rdata = 0`; `rsp_err = 1`.
- Store: for each lane i with `mask[i]`, write `mem[idx]` lane i from `wdata` lane i. Other lanes are unchanged. A store with mask 0 is legal: no change, no error. `rsp_rdata = 0`.
- Load: `rsp_rdata = mem[idx]`, full word, mask ignored. The value is the memory contents before the access edge.
- `req_*` inputs are only sampled in IDLE and may change freely afterwards.

## Timing
- Reset values (edge with `rst == 0`):
  - state IDLE; `cnt = 0`
  - `req_ready = 1` from the following cycle
  - `rsp_valid = 0`; `rsp_rdata = 0`; `rsp_err = 0`
- Memory contents are not reset.
- Latency: request accepted at edge E0 gives `rsp_valid` high after edge E0 + WAIT_CYCLES + 1.
- Minimum spacing between accepted requests is WAIT_CYCLES + 3 cycles when `rsp_ready` is tied high.
- Reset mid-operation:
  - An access still in BUSY with `cnt != 0` is abandoned; no write occurs.
  - A pending response is dropped.
  - Reset has priority over every other event in the same cycle.
- `rsp_ready` held low: the block stays in RESP indefinitely and `req_ready` stays 0.
- `rsp_ready` high while `rsp_valid` is 0 has no effect.
- WAIT_CYCLES = 0: BUSY lasts exactly one cycle.

## Test plan
- Reset then idle (`rst=0` for 2 cycles, then 1) -> `req_ready=1`, `rsp_valid=0`, `rsp_rdata=0`, `rsp_err=0`.
- WAIT_CYCLES=2: store addr 0x10, mask 4'b1111, data 0xDEADBEEF, then load addr 0x10 -> store `rsp_valid` 3 cycles after accept with `rsp_err=0`; load returns 0xDEADBEEF, also 3 cycles after accept.
- Byte mask: preload 0x11223344 at 0x20, store mask 4'b0101 data 0xAABBCCDD, then load -> 0x11BB33DD.
- Error cases:
  - Load 0x22 (misaligned) -> `rsp_err=1`, rdata 0.
  - Store to 0x1000 (idx 1024 ≥ DEPTH) -> `rsp_err=1`; a subsequent load of 0x0 shows the word unchanged.
- Backpressure: hold `rsp_ready=0` for 5 cycles after `rsp_valid` -> response stable, `req_ready=0` throughout; IDLE one cycle after the `rsp_ready=1` edge.
- Reset mid-BUSY (WAIT_CYCLES=4): store 0xCAFEF00D to 0x40 with `rst` pulsed low one cycle after accept -> no response; a later load of 0x40 returns the prior contents.
